// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, price table and coin values
// for the vending sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DISPENSE = 2'b01,
        CHG_HI   = 2'b10,
        CHG_LO   = 2'b11
    } vend_state_t;

    // Entry k costs k units; entry 0 is "no product".
    localparam logic [3:0] PRICE_TABLE [0:7] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7
    };

    localparam int COIN1_VAL = 1;
    localparam int COIN2_VAL = 2;

endpackage

// File: rtl/vend_sequencer_if.sv
// vend_sequencer_if: front-end inputs and actuator/display outputs
// of the vending sequencer.
interface vend_sequencer_if #(
    parameter int CW = 4
);
    logic          coin1;
    logic          coin2;
    logic [2:0]    sel;
    logic          confirm;
    logic          cancel;
    logic [2:0]    dispense;
    logic          dispense_valid;
    logic          change_pulse;
    logic [CW-1:0] credit;
    logic          insufficient;
    logic          busy;
    logic [1:0]    state;

    modport master (
        output coin1, coin2, sel, confirm, cancel,
        input  dispense, dispense_valid, change_pulse,
        input  credit, insufficient, busy, state
    );

    modport slave (
        input  coin1, coin2, sel, confirm, cancel,
        output dispense, dispense_valid, change_pulse,
        output credit, insufficient, busy, state
    );
endinterface

// File: rtl/vend_sequencer_coin_credit.sv
// coin_credit: coin edge detection and the saturating credit
// register with price subtraction and unit decrement.
module coin_credit
    import vend_pkg::*;
#(
    parameter int CW         = 4,
    parameter int MAX_CREDIT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_coin1,
    input  logic          i_coin2,
    input  logic          i_add_en,
    input  logic [CW-1:0] i_sub_price,
    input  logic          i_dec1,
    output logic [CW-1:0] o_credit
);
    logic          r_coin1_q;
    logic          r_coin2_q;
    logic [CW-1:0] r_credit;
    logic          w_e1;
    logic          w_e2;
    logic [CW+1:0] w_sum;

    assign w_e1 = i_coin1 & ~r_coin1_q;
    assign w_e2 = i_coin2 & ~r_coin2_q;

    // Two spare bits so a full counter plus both coins cannot wrap.
    assign w_sum = (CW+2)'(r_credit)
                 + (w_e1 ? (CW+2)'(COIN1_VAL) : '0)
                 + (w_e2 ? (CW+2)'(COIN2_VAL) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coin1_q <= 1'b0;
            r_coin2_q <= 1'b0;
            r_credit  <= '0;
        end else begin
            r_coin1_q <= i_coin1;
            r_coin2_q <= i_coin2;
            if (i_dec1) begin
                if (r_credit != '0)
                    r_credit <= r_credit - CW'(1);
            end else if (i_sub_price != '0) begin
                r_credit <= r_credit - i_sub_price;
            end else if (i_add_en && (w_e1 || w_e2)) begin
                r_credit <= (w_sum > (CW+2)'(MAX_CREDIT))
                          ? CW'(MAX_CREDIT) : w_sum[CW-1:0];
            end
        end
    end

    assign o_credit = r_credit;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: sale/refund FSM, dispense timer and optional idle
// refund timeout (enabled by macro VEND_TIMEOUT_EN).
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int CW             = 4,
    parameter int MAX_CREDIT     = 15,
    parameter int DISP_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    vend_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(DISP_CYCLES + 1);

    if (MAX_CREDIT > (1 << CW) - 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_cfg
        $error("vend_sequencer: illegal parameter set");
    end

    vend_state_t   r_state;
    vend_state_t   w_next;
    logic [2:0]    r_disp;
    logic          r_dv;
    logic          r_cp;
    logic          r_ins;
    logic          w_ins;
    logic [CNT_W-1:0] r_cnt;
    logic [CW-1:0] w_credit;
    logic [CW-1:0] w_price;
    logic [CW-1:0] w_sub;
    logic          w_dec1;
    logic          w_add_en;
    logic          w_sale;
    logic          w_refund;
    logic          w_timeout;

    assign w_price  = CW'(PRICE_TABLE[bus.sel]);
    assign w_sale   = (r_state == IDLE) && !bus.cancel && bus.confirm
                   && (bus.sel != 3'd0) && (w_credit >= w_price);
    assign w_refund = (r_state == IDLE)
                   && ((bus.cancel && (w_credit != '0)) || w_timeout);
    assign w_add_en = (r_state == IDLE) && !w_sale;

    coin_credit #(
        .CW         (CW),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_coin_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_coin1     (bus.coin1),
        .i_coin2     (bus.coin2),
        .i_add_en    (w_add_en),
        .i_sub_price (w_sub),
        .i_dec1      (w_dec1),
        .o_credit    (w_credit)
    );

    always_comb begin
        w_next = r_state;
        w_ins  = 1'b0;
        w_sub  = '0;
        w_dec1 = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_refund) begin
                    w_next = CHG_HI;
                end else if (w_sale) begin
                    w_next = DISPENSE;
                    w_sub  = w_price;
                end else if (bus.confirm && !bus.cancel && bus.sel != 3'd0) begin
                    w_ins = 1'b1;
                end
            end
            DISPENSE: begin
                if (r_cnt == CNT_W'(DISP_CYCLES - 1))
                    w_next = (w_credit != '0) ? CHG_HI : IDLE;
            end
            CHG_HI: begin
                w_dec1 = 1'b1;
                w_next = CHG_LO;
            end
            CHG_LO: begin
                w_next = (w_credit != '0) ? CHG_HI : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_disp  <= 3'd0;
            r_dv    <= 1'b0;
            r_cp    <= 1'b0;
            r_ins   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_dv    <= (w_next == DISPENSE);
            r_cp    <= (w_next == CHG_HI);
            r_ins   <= w_ins;
            if (w_sale)
                r_disp <= bus.sel;
            else if (w_next != DISPENSE)
                r_disp <= 3'd0;
            if (r_state == DISPENSE)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
        end
    end

`ifdef VEND_TIMEOUT_EN
    logic [9:0] r_to_cnt;
    logic [2:0] r_sel_q;
    logic       r_c1_q;
    logic       r_c2_q;
    logic       w_activity;

    assign w_activity = (bus.coin1 & ~r_c1_q) | (bus.coin2 & ~r_c2_q)
                      | bus.confirm | bus.cancel | (bus.sel != r_sel_q);
    assign w_timeout  = (r_state == IDLE) && (w_credit != '0) && !w_activity
                      && (r_to_cnt >= 10'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_sel_q  <= 3'd0;
            r_c1_q   <= 1'b0;
            r_c2_q   <= 1'b0;
        end else begin
            r_sel_q <= bus.sel;
            r_c1_q  <= bus.coin1;
            r_c2_q  <= bus.coin2;
            if (r_state != IDLE || w_credit == '0 || w_activity || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 10'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign bus.dispense       = r_disp;
    assign bus.dispense_valid = r_dv;
    assign bus.change_pulse   = r_cp;
    assign bus.insufficient   = r_ins;
    assign bus.credit         = w_credit;
    assign bus.busy           = (r_state != IDLE);
    assign bus.state          = r_state;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed scenarios plus random traffic checked
// every cycle against a schedule-based model of the vending rules.
module tb_vend_sequencer;
    localparam int MAXC  = 15;
    localparam int DISPC = 4;

    typedef struct packed {
        logic [2:0] d;
        logic       dv;
        logic       cp;
        logic       ins;
        logic [3:0] cr;
        logic [1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vend_sequencer_if #(.CW(4)) bus();

    vend_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: idle decisions are made from the rules; a sale or refund
    // expands into a queue of per-cycle expected outputs.
    exp_t cur;
    exp_t q[$];
    logic p1, p2;

    function automatic exp_t mk(int d, int dv, int cp, int ins, int cr, int st);
        exp_t e;
        e.d = 3'(d); e.dv = 1'(dv); e.cp = 1'(cp);
        e.ins = 1'(ins); e.cr = 4'(cr); e.st = 2'(st);
        return e;
    endfunction

    task automatic push_refund(int c);
        for (int k = c; k >= 1; k--) begin
            q.push_back(mk(0, 0, 1, 0, k, 2));
            q.push_back(mk(0, 0, 0, 0, k - 1, 3));
        end
    endtask

    task automatic model_step();
        int add, c;
        exp_t n;
        if (!rst_n) begin
            q.delete();
            cur = '0;
            p1 = 1'b0;
            p2 = 1'b0;
            return;
        end
        add = ((bus.coin1 && !p1) ? 1 : 0) + ((bus.coin2 && !p2) ? 2 : 0);
        p1 = bus.coin1;
        p2 = bus.coin2;
        c = int'(cur.cr);
        n = mk(0, 0, 0, 0, c, 0);
        if (cur.st != 2'd0) begin
            if (q.size() > 0) n = q.pop_front();
        end else begin
            c = (c + add > MAXC) ? MAXC : c + add;
            if (bus.cancel && cur.cr != 0) begin
                push_refund(c);
                n = q.pop_front();
            end else if (bus.cancel) begin
                n = mk(0, 0, 0, 0, c, 0);
            end else if (bus.confirm && bus.sel != 0) begin
                if (int'(cur.cr) >= int'(bus.sel)) begin
                    c = int'(cur.cr) - int'(bus.sel);
                    for (int i = 0; i < DISPC; i++)
                        q.push_back(mk(bus.sel, 1, 0, 0, c, 1));
                    push_refund(c);
                    n = q.pop_front();
                end else begin
                    n = mk(0, 0, 0, 1, c, 0);
                end
            end else begin
                n = mk(0, 0, 0, 0, c, 0);
            end
        end
        cur = n;
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    always @(negedge clk) begin
        exp_t a;
        if (rst_n) begin
            a = {bus.dispense, bus.dispense_valid, bus.change_pulse,
                 bus.insufficient, bus.credit, bus.state};
            n_chk++;
            if (a !== cur || bus.busy !== (cur.st != 2'd0)) begin
                n_fail++;
                $display("FAIL cycle %0t: dut d=%0d dv=%0d cp=%0d ins=%0d cr=%0d st=%0d busy=%0d, model d=%0d dv=%0d cp=%0d ins=%0d cr=%0d st=%0d",
                    $time, a.d, a.dv, a.cp, a.ins, a.cr, a.st, bus.busy,
                    cur.d, cur.dv, cur.cp, cur.ins, cur.cr, cur.st);
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin_edge(bit two);
        if (two) bus.coin2 = 1'b1; else bus.coin1 = 1'b1;
        tick();
        bus.coin1 = 1'b0;
        bus.coin2 = 1'b0;
        tick();
    endtask

    int ncp, ndv, r;

    initial begin
        bus.coin1 = 0; bus.coin2 = 0; bus.sel = 0;
        bus.confirm = 0; bus.cancel = 0;
        tick(); tick();
        chk("reset_outputs", int'({bus.dispense, bus.dispense_valid,
            bus.change_pulse, bus.credit, bus.insufficient, bus.busy, bus.state}), 0);
        rst_n = 1'b1;

        // coin1 then coin2, then cancel refund
        bus.coin1 = 1; tick();
        chk("credit_after_coin1", int'(bus.credit), 1);
        bus.coin1 = 0; bus.coin2 = 1; tick();
        chk("credit_after_coin2", int'(bus.credit), 3);
        bus.coin2 = 0; bus.cancel = 1; tick();
        bus.cancel = 0;
        ncp = 0;
        for (int i = 0; i < 6; i++) begin
            ncp += int'(bus.change_pulse);
            tick();
        end
        chk("refund3_pulses", ncp, 3);
        chk("refund3_state", int'(bus.state), 0);
        chk("refund3_credit", int'(bus.credit), 0);

        // sale with change
        coin_edge(1); coin_edge(1); coin_edge(0);
        chk("credit5", int'(bus.credit), 5);
        bus.sel = 3; bus.confirm = 1; tick();
        bus.confirm = 0;
        chk("sale_credit", int'(bus.credit), 2);
        chk("sale_code", int'(bus.dispense), 3);
        ndv = 0; ncp = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) bus.sel = 5;
            if (i == 2) chk("latched_code", int'(bus.dispense), 3);
            ndv += int'(bus.dispense_valid);
            ncp += int'(bus.change_pulse);
            tick();
        end
        chk("sale_dv_cycles", ndv, 4);
        chk("sale_change_pulses", ncp, 2);
        chk("sale_end_state", int'(bus.state), 0);

        // low credit
        coin_edge(1);
        bus.sel = 6; bus.confirm = 1; tick();
        bus.confirm = 0;
        chk("insufficient_hi", int'(bus.insufficient), 1);
        chk("insufficient_credit", int'(bus.credit), 2);
        chk("insufficient_state", int'(bus.state), 0);
        tick();
        chk("insufficient_one_cycle", int'(bus.insufficient), 0);

        // saturation, then cancel beats confirm
        for (int i = 0; i < 8; i++) coin_edge(1);
        chk("saturated", int'(bus.credit), 15);
        bus.sel = 1; bus.confirm = 1; bus.cancel = 1; tick();
        bus.confirm = 0; bus.cancel = 0;
        chk("priority_state", int'(bus.state), 2);
        chk("priority_no_dv", int'(bus.dispense_valid), 0);
        repeat (30) tick();
        chk("sat_refund_done", int'(bus.credit), 0);

        // reset in the second dispense cycle
        coin_edge(1);
        bus.sel = 1; bus.confirm = 1; tick();
        bus.confirm = 0;
        tick();
        chk("disp_before_reset", int'(bus.dispense_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({bus.dispense, bus.dispense_valid,
            bus.change_pulse, bus.credit, bus.insufficient, bus.busy, bus.state}), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_state", int'(bus.state), 0);
        chk("post_reset_credit", int'(bus.credit), 0);

        // random traffic; confirm/cancel cycles hold coins steady
        for (int it = 0; it < 3000; it++) begin
            r = int'($urandom_range(0, 99));
            bus.confirm = 0;
            bus.cancel = 0;
            if (r < 3) bus.cancel = 1;
            else if (r < 5) begin bus.cancel = 1; bus.confirm = 1; end
            else if (r < 20) bus.confirm = 1;
            else begin
                bus.coin1 = 1'($urandom_range(0, 1));
                bus.coin2 = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) bus.sel = 3'($urandom_range(0, 7));
            if (it == 1500) rst_n = 1'b0;
            if (it == 1502) rst_n = 1'b1;
            tick();
        end

        bus.coin1 = 0; bus.coin2 = 0; bus.confirm = 0; bus.cancel = 0;
        repeat (40) tick();
        chk("final_idle", int'(bus.state), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
